// File: rtl/ras_ckpt_pkg.sv
// Shared defaults and helpers for the return-address stack and its checkpoint store.
package ras_ckpt_pkg;

  localparam int ADDR_W_DEF     = 32;
  localparam int RAS_DEPTH_DEF  = 8;
  localparam int CKPT_DEPTH_DEF = 8;

  // Width of one packed checkpoint record {tos, count, top}.
  function automatic int ckpt_rec_w(input int addr_w, input int depth);
    return $clog2(depth) + $clog2(depth + 1) + addr_w;
  endfunction

endpackage

// File: rtl/ras_ckpt_fifo.sv
// Checkpoint FIFO: holds packed {tos, count, top} records for in-flight branches.
// The caller guarantees no push into a full store unless a pop happens in the same cycle.
module ras_ckpt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data_in,
  output logic         full,
  output logic         valid,
  output logic [W-1:0] data_out
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          full_q, full_d;

  assign full     = full_q;
  assign valid    = (cnt_q != '0);
  assign data_out = mem_q[rd_q];

  // Next-state for pointers and occupancy; clear beats push/pop.
  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    if (clr) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + PW'(1);
      if (pop)  rd_d = rd_q + PW'(1);
      if (push && !pop)      cnt_d = cnt_q + CW'(1);
      else if (pop && !push) cnt_d = cnt_q - CW'(1);
    end
    full_d = (cnt_d == DEPTH_C);
  end

  // Control state with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      full_q <= full_d;
    end
  end

  // Record storage; not reset, occupancy qualifies it.
  always_ff @(posedge clk) begin
    if (push && !clr) mem_q[wr_q] <= data_in;
  end

endmodule

// File: rtl/ras_ckpt.sv
// Return-address stack with speculative checkpoints: each fetched branch snapshots
// {tos, count, top entry}; a flush restores the oldest snapshot, repairing the top slot.
module ras_ckpt
  import ras_ckpt_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DEPTH      = RAS_DEPTH_DEF,
  parameter int CKPT_DEPTH = CKPT_DEPTH_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [ADDR_W-1:0]          push_addr,
  input  logic                       pop,
  output logic [ADDR_W-1:0]          top_addr,
  output logic                       top_valid,
  output logic [$clog2(DEPTH+1)-1:0] count,
  input  logic                       branch_fetched,
  input  logic                       branch_retired,
  input  logic                       flush,
  output logic                       ckpt_full,
  output logic                       underflow
);

  localparam int TW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = ckpt_rec_w(ADDR_W, DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef struct packed {
    logic [TW-1:0]     tos;
    logic [CW-1:0]     count;
    logic [ADDR_W-1:0] top;
  } ras_ckpt_t;

  logic [ADDR_W-1:0] mem_q [DEPTH];
  logic [TW-1:0]     tos_q, tos_d;
  logic [CW-1:0]     count_q, count_d;
  logic              underflow_q, underflow_d;
  logic              mem_we;
  logic [TW-1:0]     mem_waddr;
  logic [ADDR_W-1:0] mem_wdata;
  ras_ckpt_t         ckpt_in, ckpt_out;
  logic              ckpt_valid, ckpt_push, ckpt_pop;

  assign top_valid = (count_q != '0);
  assign top_addr  = top_valid ? mem_q[tos_q] : '0;
  assign count     = count_q;
  assign underflow = underflow_q;

  // Snapshot is taken from pre-update state, so a same-cycle push/pop is not included.
  assign ckpt_in   = {tos_q, count_q, mem_q[tos_q]};
  assign ckpt_push = branch_fetched && !flush && (!ckpt_full || branch_retired);
  assign ckpt_pop  = branch_retired && !flush && ckpt_valid;

  ras_ckpt_fifo #(
    .W     (RW),
    .DEPTH (CKPT_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .clr      (flush),
    .push     (ckpt_push),
    .pop      (ckpt_pop),
    .data_in  (ckpt_in),
    .full     (ckpt_full),
    .valid    (ckpt_valid),
    .data_out (ckpt_out)
  );

  // Stack next-state: flush restore wins over push/pop; push+pop replaces the top (tail call).
  always_comb begin
    tos_d       = tos_q;
    count_d     = count_q;
    underflow_d = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = tos_q;
    mem_wdata   = push_addr;
    if (flush) begin
      if (ckpt_valid) begin
        tos_d     = ckpt_out.tos;
        count_d   = ckpt_out.count;
        mem_we    = 1'b1;
        mem_waddr = ckpt_out.tos;
        mem_wdata = ckpt_out.top;
      end
    end else if (push && pop) begin
      mem_we = 1'b1;
      if (count_q == '0) count_d = CW'(1);
    end else if (push) begin
      mem_we    = 1'b1;
      mem_waddr = tos_q + TW'(1);
      tos_d     = tos_q + TW'(1);
      if (count_q != DEPTH_C) count_d = count_q + CW'(1);
    end else if (pop) begin
      if (count_q != '0) begin
        tos_d   = tos_q - TW'(1);
        count_d = count_q - CW'(1);
      end else begin
        underflow_d = 1'b1;
      end
    end
  end

  // Pointer, occupancy and underflow pulse with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tos_q       <= '0;
      count_q     <= '0;
      underflow_q <= 1'b0;
    end else begin
      tos_q       <= tos_d;
      count_q     <= count_d;
      underflow_q <= underflow_d;
    end
  end

  // Stack RAM; not reset, top_valid qualifies the read.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  // Upstream must stall branch_fetched while the store is full and nothing retires.
  a_no_fetch_when_full: assert property (@(posedge clk) disable iff (rst)
    !(branch_fetched && ckpt_full && !branch_retired && !flush));

endmodule

// File: tb/tb_ras_ckpt.sv
// Directed bench for ras_ckpt: a table of per-cycle vectors plus hand sequences
// for reset behaviour.
module tb_ras_ckpt;

  logic        clk;
  logic        rst;
  logic        push;
  logic [31:0] push_addr;
  logic        pop;
  logic [31:0] top_addr;
  logic        top_valid;
  logic [3:0]  count;
  logic        branch_fetched;
  logic        branch_retired;
  logic        flush;
  logic        ckpt_full;
  logic        underflow;

  int nvec  = 0;
  int nfail = 0;

  typedef struct {
    logic        pu;
    logic [31:0] pa;
    logic        po;
    logic        bf;
    logic        br;
    logic        fl;
    logic [31:0] e_top;
    logic        e_vld;
    logic [3:0]  e_cnt;
    logic        e_full;
    logic        e_uf;
  } vec_t;

  vec_t vt[$];

  ras_ckpt #(.ADDR_W(32), .DEPTH(8), .CKPT_DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .push           (push),
    .push_addr      (push_addr),
    .pop            (pop),
    .top_addr       (top_addr),
    .top_valid      (top_valid),
    .count          (count),
    .branch_fetched (branch_fetched),
    .branch_retired (branch_retired),
    .flush          (flush),
    .ckpt_full      (ckpt_full),
    .underflow      (underflow)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic add(input logic pu, input logic [31:0] pa, input logic po,
                     input logic bf, input logic br, input logic fl,
                     input logic [31:0] et, input logic ev, input logic [3:0] ec,
                     input logic ef, input logic eu);
    vec_t v;
    v.pu = pu; v.pa = pa; v.po = po; v.bf = bf; v.br = br; v.fl = fl;
    v.e_top = et; v.e_vld = ev; v.e_cnt = ec; v.e_full = ef; v.e_uf = eu;
    vt.push_back(v);
  endtask

  task automatic check(input string nm, input logic [31:0] et, input logic ev,
                       input logic [3:0] ec, input logic ef, input logic eu);
    nvec++;
    if (top_addr !== et || top_valid !== ev || count !== ec ||
        ckpt_full !== ef || underflow !== eu) begin
      nfail++;
      $display("FAIL %s: got top=%h vld=%b cnt=%0d full=%b uf=%b, want top=%h vld=%b cnt=%0d full=%b uf=%b",
               nm, top_addr, top_valid, count, ckpt_full, underflow, et, ev, ec, ef, eu);
    end
  endtask

  task automatic idle();
    push = 1'b0; push_addr = '0; pop = 1'b0;
    branch_fetched = 1'b0; branch_retired = 1'b0; flush = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();

    // Basic push/pop, then drain to empty
    add(1, 32'h100, 0, 0, 0, 0, 32'h100, 1, 1, 0, 0);
    add(1, 32'h200, 0, 0, 0, 0, 32'h200, 1, 2, 0, 0);
    add(1, 32'h300, 0, 0, 0, 0, 32'h300, 1, 3, 0, 0);
    add(0, 0,       1, 0, 0, 0, 32'h200, 1, 2, 0, 0);
    add(0, 0,       1, 0, 0, 0, 32'h100, 1, 1, 0, 0);
    add(0, 0,       1, 0, 0, 0, 32'h0,   0, 0, 0, 0);
    // Nine pushes on an 8-deep stack: count saturates, oldest overwritten
    for (int i = 1; i <= 9; i++)
      add(1, 32'(i * 16), 0, 0, 0, 0, 32'(i * 16), 1, 4'((i > 8) ? 8 : i), 0, 0);
    for (int j = 1; j <= 7; j++)
      add(0, 0, 1, 0, 0, 0, 32'((9 - j) * 16), 1, 4'(8 - j), 0, 0);
    add(0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0);
    add(0, 0, 1, 0, 0, 0, 32'h0, 0, 0, 0, 1);   // pop on empty -> underflow pulse
    add(0, 0, 0, 0, 0, 0, 32'h0, 0, 0, 0, 0);   // pulse lasts one cycle
    // Tail call on the wrong path, then flush repairs the clobbered top
    add(1, 32'hA0, 0, 0, 0, 0, 32'hA0, 1, 1, 0, 0);
    add(1, 32'hB0, 0, 0, 0, 0, 32'hB0, 1, 2, 0, 0);
    add(0, 0,      0, 1, 0, 0, 32'hB0, 1, 2, 0, 0);
    add(1, 32'hC0, 1, 0, 0, 0, 32'hC0, 1, 2, 0, 0);
    add(0, 0,      0, 0, 0, 1, 32'hB0, 1, 2, 0, 0);
    // Two checkpoints, flush restores the oldest
    add(0, 0,      1, 0, 0, 0, 32'hA0, 1, 1, 0, 0);
    add(0, 0,      1, 0, 0, 0, 32'h0,  0, 0, 0, 0);
    add(1, 32'h40, 0, 0, 0, 0, 32'h40, 1, 1, 0, 0);
    add(0, 0,      0, 1, 0, 0, 32'h40, 1, 1, 0, 0);
    add(1, 32'h50, 0, 0, 0, 0, 32'h50, 1, 2, 0, 0);
    add(1, 32'h60, 0, 0, 0, 0, 32'h60, 1, 3, 0, 0);
    add(0, 0,      0, 1, 0, 0, 32'h60, 1, 3, 0, 0);
    add(0, 0,      0, 0, 0, 1, 32'h40, 1, 1, 0, 0);
    add(0, 0,      0, 0, 1, 0, 32'h40, 1, 1, 0, 0);   // retire on empty store ignored
    // Fill the store: full exactly at 8 only if the flush left it empty
    for (int k = 1; k <= 8; k++)
      add(0, 0, 0, 1, 0, 0, 32'h40, 1, 1, (k == 8), 0);
    add(0, 0, 0, 1, 1, 0, 32'h40, 1, 1, 1, 0);        // fetch+retire on full
    add(0, 0, 0, 0, 1, 0, 32'h40, 1, 1, 0, 0);        // retire one
    add(1, 32'h55, 0, 0, 0, 0, 32'h55, 1, 2, 0, 0);
    // Flush with branch_fetched and push: only the restore happens
    add(1, 32'h77, 0, 1, 0, 1, 32'h40, 1, 1, 0, 0);
    add(1, 32'h66, 0, 0, 0, 0, 32'h66, 1, 2, 0, 0);
    add(0, 0,      0, 0, 0, 1, 32'h66, 1, 2, 0, 0);   // store was left empty

    // Asynchronous reset without a clock edge
    #1 rst = 1'b1;
    #2 check("reset_state", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    rst = 1'b0;

    foreach (vt[i]) begin
      push           = vt[i].pu;
      push_addr      = vt[i].pa;
      pop            = vt[i].po;
      branch_fetched = vt[i].bf;
      branch_retired = vt[i].br;
      flush          = vt[i].fl;
      @(posedge clk); #1;
      idle();
      check($sformatf("vec%0d", i), vt[i].e_top, vt[i].e_vld, vt[i].e_cnt,
            vt[i].e_full, vt[i].e_uf);
    end

    // Store is non-empty going into the mid-run reset
    branch_fetched = 1'b1;
    @(posedge clk); #1;
    idle();
    check("pre_rst", 32'h66, 1'b1, 4'd2, 1'b0, 1'b0);
    rst = 1'b1;
    #2 check("async_rst", 32'h0, 1'b0, 4'd0, 1'b0, 1'b0);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    // Store emptied by reset: a flush must not restore anything
    push = 1'b1; push_addr = 32'h123;
    @(posedge clk); #1;
    idle();
    check("post_rst_push", 32'h123, 1'b1, 4'd1, 1'b0, 1'b0);
    flush = 1'b1;
    @(posedge clk); #1;
    idle();
    check("post_rst_flush", 32'h123, 1'b1, 4'd1, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
